// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC owner with static prediction, in-flight prediction FIFO, redirect/flush and counters
//   clk, rst          clock, synchronous active-high reset
//   imem_addr/instr   fetch address (the PC) and the instruction returned for it
//   id_*              IF/ID outputs (valid, instr, pc, pred_taken), held while id_ready=0
//   ex_res_*          EX resolution of the oldest in-flight control-flow instruction
//   trap_valid/pc     trap redirect request, wins over a same-cycle mispredict
//   redirect          one-cycle registered flush pulse
//   cf_count, mispred_count  saturating statistics; q_err sticky resolve-on-empty flag
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_pred_taken,
  input  logic        ex_res_valid,
  input  logic        ex_res_taken,
  input  logic [31:0] ex_res_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        redirect,
  output logic [31:0] cf_count,
  output logic [31:0] mispred_count,
  output logic        q_err
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fall;
  } ent_t;
  ent_t fifo [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] pc, pc_4, j_imm, b_imm, pred_target, correct_pc;
  logic is_jal, is_jalr, is_br, is_cf, pred_taken;
  logic empty, full, pop, push, mispredict, flush, fetch_fire;
  ent_t head;
  assign imem_addr = pc;
  always_comb begin
    is_jal      = imem_instr[6:0] == 7'b1101111;
    is_jalr     = imem_instr[6:0] == 7'b1100111;
    is_br       = imem_instr[6:0] == 7'b1100011;
    is_cf       = is_jal | is_jalr | is_br;
    j_imm       = {{12{imem_instr[31]}}, imem_instr[19:12], imem_instr[20], imem_instr[30:21], 1'b0};
    b_imm       = {{20{imem_instr[31]}}, imem_instr[7], imem_instr[30:25], imem_instr[11:8], 1'b0};
    pc_4        = pc + 32'd4;
    pred_taken  = is_jal | (is_br & b_imm[31]);
    pred_target = is_jal ? pc + j_imm : (is_br & b_imm[31]) ? pc + b_imm : pc_4;
    empty       = wr_ptr == rd_ptr;
    full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
    head        = fifo[rd_ptr[AW-1:0]];
    pop         = ex_res_valid & !empty;
    mispredict  = pop & ((ex_res_taken != head.taken) | (ex_res_taken & (ex_res_target != head.target)));
    correct_pc  = ex_res_taken ? ex_res_target : head.fall;
    flush       = trap_valid | mispredict;
    fetch_fire  = id_ready & !flush & !(is_cf & full & !pop);
    push        = fetch_fire & is_cf;
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr[AW-1:0]] <= '{pred_taken, pred_target, pc_4};
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      id_valid      <= 1'b0;
      id_instr      <= '0;
      id_pc         <= '0;
      id_pred_taken <= 1'b0;
      redirect      <= 1'b0;
      cf_count      <= '0;
      mispred_count <= '0;
      q_err         <= 1'b0;
    end else begin
      redirect <= flush;
      if (pop) cf_count <= cf_count + {31'b0, cf_count != '1};
      if (mispredict) mispred_count <= mispred_count + {31'b0, mispred_count != '1};
      if (ex_res_valid & empty) q_err <= 1'b1;
      if (flush) begin
        pc       <= trap_valid ? trap_pc : correct_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        id_valid <= 1'b0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (fetch_fire) begin
          pc            <= pred_target;
          id_valid      <= 1'b1;
          id_instr      <= imem_instr;
          id_pc         <= pc;
          id_pred_taken <= pred_taken;
        end else if (id_ready) id_valid <= 1'b0;
      end
    end
  end
endmodule
